// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM stage: access sizes, FSM states,
// writeback-control bit positions and byte-lane helpers.
package mem_pkg;

    localparam int BYTE_LANES   = 8;
    localparam int OFFSET_WIDTH = 3;

    // Bit positions inside the 3-bit writeback control bundle
    localparam int WB_ECALL      = 2;
    localparam int WB_REG_WRITE  = 1;
    localparam int WB_MEM_TO_REG = 0;

    typedef enum logic [1:0] {
        MEM_B,
        MEM_H,
        MEM_W,
        MEM_D
    } mem_size_e;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        DONE,
        DRAIN
    } mem_state_e;

    function automatic logic [BYTE_LANES-1:0] size_strobe(input mem_size_e size);
        logic [BYTE_LANES-1:0] strobe;
        case (size)
            MEM_B:   strobe = 8'h01;
            MEM_H:   strobe = 8'h03;
            MEM_W:   strobe = 8'h0F;
            default: strobe = 8'hFF;
        endcase
        return strobe;
    endfunction

    function automatic logic offset_misaligned(input mem_size_e size,
                                               input logic [OFFSET_WIDTH-1:0] offset);
        logic bad;
        case (size)
            MEM_H:   bad = offset[0];
            MEM_W:   bad = |offset[1:0];
            MEM_D:   bad = |offset;
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed bytes out of a raw cache word and sign- or
// zero-extends them to the full datapath width.
module load_align
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic [OFFSET_WIDTH-1:0] offset,
    input  mem_size_e               size,
    input  logic                    zero_ext,
    output logic [DATA_WIDTH-1:0]   data
);

    logic [DATA_WIDTH-1:0] shifted;

    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        data    = shifted;
        case (size)
            MEM_B: data = zero_ext ? {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]}
                                   : {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
            MEM_H: data = zero_ext ? {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]}
                                   : {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
            MEM_W: data = zero_ext ? {{(DATA_WIDTH-32){1'b0}}, shifted[31:0]}
                                   : {{(DATA_WIDTH-32){shifted[31]}}, shifted[31:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues one data-cache access per load/store, stalls the
// pipeline until it completes, and passes writeback information to MEM/WB.
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH   = 64,
    parameter int REG_ID_WIDTH = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    valid_in,
    input  logic [DATA_WIDTH-1:0]   pc_in,
    input  logic [DATA_WIDTH-1:0]   alu_in,
    input  logic [DATA_WIDTH-1:0]   store_data_in,
    input  logic [REG_ID_WIDTH-1:0] dest_in,
    input  logic                    mem_read_in,
    input  logic                    mem_write_in,
    input  logic [1:0]              mem_size_in,
    input  logic                    mem_unsigned_in,
    input  logic [2:0]              wb_control_in,
    output logic                    dc_req_valid,
    input  logic                    dc_req_ready,
    output logic [DATA_WIDTH-1:0]   dc_req_addr,
    output logic                    dc_req_we,
    output logic [DATA_WIDTH-1:0]   dc_req_wdata,
    output logic [BYTE_LANES-1:0]   dc_req_wstrb,
    input  logic                    dc_resp_valid,
    input  logic [DATA_WIDTH-1:0]   dc_resp_rdata,
    output logic                    mem_stall,
    output logic [DATA_WIDTH-1:0]   pc_out,
    output logic [DATA_WIDTH-1:0]   alu_out,
    output logic [DATA_WIDTH-1:0]   mem_data_out,
    output logic [REG_ID_WIDTH-1:0] dest_out,
    output logic [2:0]              wb_control_out,
    output logic                    misaligned_out
);

    mem_state_e              state;
    mem_state_e              next_state;
    logic [DATA_WIDTH-1:0]   load_q;
    logic [DATA_WIDTH-1:0]   aligned_data;
    logic [OFFSET_WIDTH-1:0] offset;
    mem_size_e               size;
    logic                    is_mem;
    logic                    misaligned;
    logic                    mem_op;
    logic                    capture;

    assign offset     = alu_in[OFFSET_WIDTH-1:0];
    assign size       = mem_size_e'(mem_size_in);
    assign is_mem     = valid_in & (mem_read_in | mem_write_in);
    assign misaligned = is_mem & offset_misaligned(size, offset);
    assign mem_op     = is_mem & ~misaligned;

    load_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_load_align (
        .rdata    (dc_resp_rdata),
        .offset   (offset),
        .size     (size),
        .zero_ext (mem_unsigned_in),
        .data     (aligned_data)
    );

    // Store-side capture holds zero so a completed store never shows stale load data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            load_q <= '0;
        end else begin
            state <= next_state;
            if (capture) begin
                load_q <= mem_read_in ? aligned_data : '0;
            end
        end
    end

    // A flush that coincides with the handshake still owes us a response, so it drains
    always_comb begin
        next_state = state;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (mem_op && !flush) begin
                    next_state = REQ;
                end
            end
            REQ: begin
                if (dc_req_ready) begin
                    if (flush) begin
                        next_state = dc_resp_valid ? IDLE : DRAIN;
                    end else if (dc_resp_valid) begin
                        next_state = DONE;
                        capture    = 1'b1;
                    end else begin
                        next_state = WAIT;
                    end
                end else if (flush) begin
                    next_state = IDLE;
                end
            end
            WAIT: begin
                if (dc_resp_valid) begin
                    if (flush) begin
                        next_state = IDLE;
                    end else begin
                        next_state = DONE;
                        capture    = 1'b1;
                    end
                end else if (flush) begin
                    next_state = DRAIN;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            DRAIN: begin
                if (dc_resp_valid) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_comb begin
        dc_req_valid = (state == REQ);
        dc_req_addr  = {alu_in[DATA_WIDTH-1:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
        dc_req_we    = mem_write_in;
        dc_req_wdata = store_data_in << {offset, 3'b000};
        dc_req_wstrb = size_strobe(size) << offset;

        // Reset gating keeps the stall low even while EX/MEM still shows a memory op
        mem_stall = reset & (((state == IDLE) & mem_op & ~flush) |
                             (state == REQ) | (state == WAIT) | (state == DRAIN));

        pc_out         = pc_in;
        alu_out        = alu_in;
        dest_out       = dest_in;
        misaligned_out = misaligned;
        mem_data_out   = (state == DONE) ? load_q : '0;

        wb_control_out                = '0;
        wb_control_out[WB_ECALL]      = wb_control_in[WB_ECALL];
        wb_control_out[WB_MEM_TO_REG] = wb_control_in[WB_MEM_TO_REG];
        wb_control_out[WB_REG_WRITE]  = wb_control_in[WB_REG_WRITE] & valid_in & ~misaligned;
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: directed loads/stores against a
// simple latency-configurable cache model, plus flush and reset scenarios.
module tb_mem_access_stage;

    localparam int DW = 64;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          valid_in;
    logic [DW-1:0] pc_in;
    logic [DW-1:0] alu_in;
    logic [DW-1:0] store_data_in;
    logic [RW-1:0] dest_in;
    logic          mem_read_in;
    logic          mem_write_in;
    logic [1:0]    mem_size_in;
    logic          mem_unsigned_in;
    logic [2:0]    wb_control_in;
    logic          dc_req_valid;
    logic          dc_req_ready;
    logic [DW-1:0] dc_req_addr;
    logic          dc_req_we;
    logic [DW-1:0] dc_req_wdata;
    logic [7:0]    dc_req_wstrb;
    logic          dc_resp_valid;
    logic [DW-1:0] dc_resp_rdata;
    logic          mem_stall;
    logic [DW-1:0] pc_out;
    logic [DW-1:0] alu_out;
    logic [DW-1:0] mem_data_out;
    logic [RW-1:0] dest_out;
    logic [2:0]    wb_control_out;
    logic          misaligned_out;

    typedef struct packed {
        logic [63:0] addr;
        logic        we;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
    } req_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] alu;
        logic [63:0] data;
        logic [4:0]  dest;
        logic [2:0]  wb;
        logic        mis;
    } out_t;

    req_t        req_q[$];
    out_t        out_q[$];
    int          checks = 0;
    int          fails = 0;
    int          op_count = 0;
    int          resp_delay = 0;
    logic [63:0] resp_data = '0;

    mem_access_stage #(
        .DATA_WIDTH   (DW),
        .REG_ID_WIDTH (RW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .flush           (flush),
        .valid_in        (valid_in),
        .pc_in           (pc_in),
        .alu_in          (alu_in),
        .store_data_in   (store_data_in),
        .dest_in         (dest_in),
        .mem_read_in     (mem_read_in),
        .mem_write_in    (mem_write_in),
        .mem_size_in     (mem_size_in),
        .mem_unsigned_in (mem_unsigned_in),
        .wb_control_in   (wb_control_in),
        .dc_req_valid    (dc_req_valid),
        .dc_req_ready    (dc_req_ready),
        .dc_req_addr     (dc_req_addr),
        .dc_req_we       (dc_req_we),
        .dc_req_wdata    (dc_req_wdata),
        .dc_req_wstrb    (dc_req_wstrb),
        .dc_resp_valid   (dc_resp_valid),
        .dc_resp_rdata   (dc_resp_rdata),
        .mem_stall       (mem_stall),
        .pc_out          (pc_out),
        .alu_out         (alu_out),
        .mem_data_out    (mem_data_out),
        .dest_out        (dest_out),
        .wb_control_out  (wb_control_out),
        .misaligned_out  (misaligned_out)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Cache model: one response per accepted request, resp_delay cycles after the handshake
    initial begin
        int          d;
        logic [63:0] r;
        dc_req_ready  = 1'b1;
        dc_resp_valid = 1'b0;
        dc_resp_rdata = '0;
        forever begin
            @(negedge clk);
            if (reset && dc_req_valid && dc_req_ready) begin
                d = resp_delay;
                r = resp_data;
                if (d > 0) begin
                    repeat (d) @(posedge clk);
                    #1;
                end
                dc_resp_valid = 1'b1;
                dc_resp_rdata = r;
                @(posedge clk);
                #1;
                dc_resp_valid = 1'b0;
                dc_resp_rdata = '0;
            end
        end
    end

    // Monitor: compares accepted requests and retiring instructions against the queues
    always @(negedge clk) begin
        req_t re;
        out_t oe;
        if (reset && dc_req_valid && dc_req_ready) begin
            if (req_q.size() == 0) begin
                checks++;
                fails++;
                $display("[TB] FAIL unexpected_request: got addr 0x%0h, expected no request", dc_req_addr);
            end else begin
                re = req_q.pop_front();
                check_output("req_addr", dc_req_addr, re.addr);
                check_output("req_we", 64'(dc_req_we), 64'(re.we));
                check_output("req_wdata", dc_req_wdata, re.wdata);
                check_output("req_wstrb", 64'(dc_req_wstrb), 64'(re.wstrb));
            end
        end
        if (reset && valid_in && !flush && !mem_stall) begin
            if (out_q.size() == 0) begin
                checks++;
                fails++;
                $display("[TB] FAIL unexpected_output: got pc 0x%0h, expected no retirement", pc_out);
            end else begin
                oe = out_q.pop_front();
                check_output("pc_out", pc_out, oe.pc);
                check_output("alu_out", alu_out, oe.alu);
                check_output("mem_data_out", mem_data_out, oe.data);
                check_output("dest_out", 64'(dest_out), 64'(oe.dest));
                check_output("wb_control_out", 64'(wb_control_out), 64'(oe.wb));
                check_output("misaligned_out", 64'(misaligned_out), 64'(oe.mis));
            end
        end
    end

    task automatic clear_inputs();
        flush           = 1'b0;
        valid_in        = 1'b0;
        pc_in           = '0;
        alu_in          = '0;
        store_data_in   = '0;
        dest_in         = '0;
        mem_read_in     = 1'b0;
        mem_write_in    = 1'b0;
        mem_size_in     = 2'd0;
        mem_unsigned_in = 1'b0;
        wb_control_in   = 3'b000;
    endtask

    task automatic apply_stimulus(input logic rd, input logic wr, input logic [1:0] size,
                                  input logic uns, input logic [63:0] addr,
                                  input logic [63:0] sdata, input logic [2:0] wb);
        op_count++;
        valid_in        = 1'b1;
        pc_in           = 64'h8000_0000 + 64'(op_count * 4);
        alu_in          = addr;
        store_data_in   = sdata;
        dest_in         = 5'(op_count);
        mem_read_in     = rd;
        mem_write_in    = wr;
        mem_size_in     = size;
        mem_unsigned_in = uns;
        wb_control_in   = wb;
    endtask

    // Counts stalled cycles starting at the next negedge; returns at the first unstalled one
    task automatic count_stall(input string name, input int exp_stall);
        int cnt;
        cnt = 0;
        @(negedge clk);
        while (mem_stall && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        if (cnt >= 40) begin
            checks++;
            fails++;
            $display("[TB] FAIL %s_stall_timeout: got >=40 stall cycles, expected %0d", name, exp_stall);
        end else begin
            check_output({name, "_stall_cycles"}, 64'(cnt), 64'(exp_stall));
        end
    endtask

    task automatic run_op(input string name, input logic rd, input logic wr, input logic [1:0] size,
                          input logic uns, input logic [63:0] addr, input logic [63:0] sdata,
                          input logic [63:0] rdata, input logic [2:0] wb, input int delay,
                          input logic [63:0] exp_data, input logic [63:0] exp_addr,
                          input logic [63:0] exp_wdata, input logic [7:0] exp_wstrb,
                          input logic exp_mis, input logic [2:0] exp_wb, input int exp_stall);
        req_t r;
        out_t o;
        if ((rd || wr) && !exp_mis) begin
            r.addr  = exp_addr;
            r.we    = wr;
            r.wdata = exp_wdata;
            r.wstrb = exp_wstrb;
            req_q.push_back(r);
        end
        o.pc   = 64'h8000_0000 + 64'((op_count + 1) * 4);
        o.alu  = addr;
        o.data = exp_data;
        o.dest = 5'(op_count + 1);
        o.wb   = exp_wb;
        o.mis  = exp_mis;
        out_q.push_back(o);
        resp_delay = delay;
        resp_data  = rdata;
        apply_stimulus(rd, wr, size, uns, addr, sdata, wb);
        count_stall(name, exp_stall);
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    initial begin
        req_t r;
        reset = 1'b0;
        clear_inputs();
        #2;
        check_output("reset_req_valid", 64'(dc_req_valid), 64'd0);
        check_output("reset_stall", 64'(mem_stall), 64'd0);
        check_output("reset_mem_data", mem_data_out, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        //      name   rd wr sz uns addr         sdata                  rdata                  wb    dly exp_data               req_addr     wdata                  wstrb  mis wb_out stall
        run_op("ld",   1, 0, 3, 0, 64'h1000, 64'h0,                 64'h1122334455667788, 3'b011, 2, 64'h1122334455667788, 64'h1000, 64'h0,                 8'hFF, 0, 3'b011, 4);
        run_op("lb_s", 1, 0, 0, 0, 64'h1003, 64'h0,                 64'h0000000080000000, 3'b011, 2, 64'hFFFFFFFFFFFFFF80, 64'h1000, 64'h0,                 8'h08, 0, 3'b011, 4);
        run_op("lbu",  1, 0, 0, 1, 64'h1003, 64'h0,                 64'h0000000080000000, 3'b011, 2, 64'h80,               64'h1000, 64'h0,                 8'h08, 0, 3'b011, 4);
        run_op("sh",   0, 1, 1, 0, 64'h2006, 64'hBEEF,              64'h0,                3'b000, 1, 64'h0,                64'h2000, 64'hBEEF000000000000, 8'hC0, 0, 3'b000, 3);
        run_op("lw_mis", 1, 0, 2, 0, 64'h3002, 64'h0,               64'h0,                3'b011, 0, 64'h0,                64'h0,    64'h0,                 8'h00, 1, 3'b001, 0);
        run_op("alu",  0, 0, 0, 0, 64'h55,   64'h0,                 64'h0,                3'b110, 0, 64'h0,                64'h0,    64'h0,                 8'h00, 0, 3'b110, 0);
        run_op("lw0",  1, 0, 2, 0, 64'h1004, 64'h0,                 64'hDEADBEEF00000000, 3'b011, 0, 64'hFFFFFFFFDEADBEEF, 64'h1000, 64'h0,                 8'hF0, 0, 3'b011, 2);
        run_op("lhu",  1, 0, 1, 1, 64'h100A, 64'h0,                 64'h00000000ABCD0000, 3'b011, 1, 64'hABCD,             64'h1008, 64'h0,                 8'h0C, 0, 3'b011, 3);
        run_op("sd",   0, 1, 3, 0, 64'h2000, 64'h0123456789ABCDEF,  64'h0,                3'b000, 2, 64'h0,                64'h2000, 64'h0123456789ABCDEF, 8'hFF, 0, 3'b000, 4);
        run_op("sb",   0, 1, 0, 0, 64'h2005, 64'h5A,                64'h0,                3'b000, 0, 64'h0,                64'h2000, 64'h00005A0000000000, 8'h20, 0, 3'b000, 2);

        // Flush while the request is still waiting for ready: nothing reaches the cache
        dc_req_ready = 1'b0;
        apply_stimulus(1, 0, 3, 0, 64'h6000, 64'h0, 3'b011);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_output("req_flush_valid", 64'(dc_req_valid), 64'd1);
        check_output("req_flush_stall", 64'(mem_stall), 64'd1);
        @(posedge clk);
        #1;
        flush    = 1'b1;
        valid_in = 1'b0;
        @(posedge clk);
        #1;
        clear_inputs();
        @(negedge clk);
        check_output("req_flush_idle_valid", 64'(dc_req_valid), 64'd0);
        check_output("req_flush_idle_stall", 64'(mem_stall), 64'd0);
        @(posedge clk);
        #1;
        dc_req_ready = 1'b1;

        // Flush in WAIT: drains the outstanding response with no DONE cycle
        r.addr = 64'h5000; r.we = 1'b0; r.wdata = 64'h0; r.wstrb = 8'hFF;
        req_q.push_back(r);
        resp_delay = 4;
        resp_data  = 64'hAAAA5555AAAA5555;
        apply_stimulus(1, 0, 3, 0, 64'h5000, 64'h0, 3'b011);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        flush    = 1'b1;
        valid_in = 1'b0;
        @(negedge clk);
        check_output("wait_flush_stall", 64'(mem_stall), 64'd1);
        @(posedge clk);
        #1;
        flush = 1'b0;
        count_stall("drain", 3);
        check_output("drain_no_done_data", mem_data_out, 64'd0);
        @(posedge clk);
        #1;
        clear_inputs();
        run_op("ld_after_flush", 1, 0, 3, 0, 64'h1008, 64'h0, 64'h0102030405060708, 3'b011, 1,
               64'h0102030405060708, 64'h1008, 64'h0, 8'hFF, 0, 3'b011, 3);

        // Asynchronous reset in WAIT
        r.addr = 64'h4000; r.we = 1'b0; r.wdata = 64'h0; r.wstrb = 8'hFF;
        req_q.push_back(r);
        resp_delay = 3;
        resp_data  = 64'h1234;
        apply_stimulus(1, 0, 3, 0, 64'h4000, 64'h0, 3'b011);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check_output("wait_stall_pre_reset", 64'(mem_stall), 64'd1);
        #1;
        reset = 1'b0;
        #1;
        check_output("async_reset_req_valid", 64'(dc_req_valid), 64'd0);
        check_output("async_reset_stall", 64'(mem_stall), 64'd0);
        clear_inputs();
        repeat (6) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check_output("post_reset_stall", 64'(mem_stall), 64'd0);
        check_output("post_reset_req_valid", 64'(dc_req_valid), 64'd0);
        check_output("post_reset_mem_data", mem_data_out, 64'd0);
        @(posedge clk);
        #1;
        run_op("ld_after_reset", 1, 0, 2, 1, 64'h1004, 64'h0, 64'h89ABCDEF00000000, 3'b011, 2,
               64'h0000000089ABCDEF, 64'h1000, 64'h0, 8'hF0, 0, 3'b011, 4);

        repeat (2) @(posedge clk);
        check_output("req_queue_empty", 64'(req_q.size()), 64'd0);
        check_output("out_queue_empty", 64'(out_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before 200000 time units");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
